// File: rtl/bp_fe_ras_stack_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bp_fe_ras_stack_pkg : operation encoding for the return stack    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package bp_fe_ras_stack_pkg;

   typedef enum logic [1:0] {
      e_ras_idle = 2'b00,
      e_ras_pop  = 2'b01,
      e_ras_push = 2'b10,
      e_ras_swap = 2'b11
   } bp_fe_ras_op_e;

   // A call and a return in the same instruction is a coroutine swap.
   function automatic bp_fe_ras_op_e ras_op_decode(input logic call, input logic ret);
      return bp_fe_ras_op_e'({call, ret});
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_fe_ras_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bp_fe_ras_stack : checkpointable circular return address stack   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bp_fe_ras_stack
   import bp_fe_ras_stack_pkg::*;
#(
   parameter int vaddr_width_p = 39,
   parameter int ras_els_p = 8,
   localparam int ras_ptr_width_lp = $clog2(ras_els_p),
   localparam int ras_cnt_width_lp = $clog2(ras_els_p + 1),
   localparam int ras_ckpt_width_lp = ras_ptr_width_lp + ras_cnt_width_lp + vaddr_width_p
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         call_i,
   input  logic                         return_i,
   input  logic [vaddr_width_p-1:0]     addr_i,
   output logic [vaddr_width_p-1:0]     tgt_o,
   output logic                         v_o,
   output logic [ras_ckpt_width_lp-1:0] ckpt_o,
   input  logic                         restore_v_i,
   input  logic [ras_ckpt_width_lp-1:0] restore_ckpt_i,
   input  logic                         restore_call_i,
   input  logic                         restore_return_i,
   input  logic [vaddr_width_p-1:0]     restore_addr_i
);

   localparam logic [ras_cnt_width_lp-1:0] cnt_full_lp = ras_cnt_width_lp'(ras_els_p);

   logic [ras_ptr_width_lp-1:0] ptr_q, ptr_d;
   logic [ras_cnt_width_lp-1:0] cnt_q, cnt_d;
   logic [vaddr_width_p-1:0]    mem_q [ras_els_p];

   logic [ras_ptr_width_lp-1:0] ckpt_ptr;
   logic [ras_cnt_width_lp-1:0] ckpt_cnt;
   logic [vaddr_width_p-1:0]    ckpt_top;

   assign {ckpt_ptr, ckpt_cnt, ckpt_top} = restore_ckpt_i;

   logic [ras_ptr_width_lp-1:0] base_ptr;
   logic [ras_cnt_width_lp-1:0] base_cnt;
   logic [vaddr_width_p-1:0]    push_addr;
   bp_fe_ras_op_e               op;
   logic                        wr_v;
   logic [ras_ptr_width_lp-1:0] wr_idx;

   // A restore rebases the state first; the redirecting op is then applied on top.
   always_comb begin
      base_ptr  = restore_v_i ? ckpt_ptr : ptr_q;
      base_cnt  = restore_v_i ? ckpt_cnt : cnt_q;
      push_addr = restore_v_i ? restore_addr_i : addr_i;
      op        = restore_v_i ? ras_op_decode(restore_call_i, restore_return_i)
                              : ras_op_decode(call_i, return_i);
      ptr_d     = base_ptr;
      cnt_d     = base_cnt;
      wr_v      = 1'b0;
      wr_idx    = base_ptr;
      case (op)
         e_ras_push: begin
            ptr_d  = base_ptr + ras_ptr_width_lp'(1);
            cnt_d  = (base_cnt == cnt_full_lp) ? base_cnt : base_cnt + ras_cnt_width_lp'(1);
            wr_v   = 1'b1;
            wr_idx = base_ptr + ras_ptr_width_lp'(1);
         end
         e_ras_pop: begin
            if (base_cnt != '0) begin
               ptr_d = base_ptr - ras_ptr_width_lp'(1);
               cnt_d = base_cnt - ras_cnt_width_lp'(1);
            end
         end
         e_ras_swap: begin
            wr_v   = 1'b1;
            wr_idx = base_ptr;
            cnt_d  = (base_cnt == '0) ? ras_cnt_width_lp'(1) : base_cnt;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Repair write precedes the op write so a swap on the restored top wins.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         if (restore_v_i)
            mem_q[ckpt_ptr] <= ckpt_top;
         if (wr_v)
            mem_q[wr_idx] <= push_addr;
      end
   end

   assign tgt_o  = mem_q[ptr_q];
   assign v_o    = (cnt_q != '0);
   assign ckpt_o = {ptr_q, cnt_q, tgt_o};

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_ras_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bp_fe_ras_stack : directed and randomized return stack bench  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_bp_fe_ras_stack;

   localparam int VW  = 39;
   localparam int E   = 8;
   localparam int PW  = $clog2(E);
   localparam int CW  = $clog2(E + 1);
   localparam int CKW = PW + CW + VW;

   logic           clk = 1'b0;
   logic           reset_i = 1'b1;
   logic           call_i = 1'b0, return_i = 1'b0;
   logic [VW-1:0]  addr_i = '0;
   logic [VW-1:0]  tgt_o;
   logic           v_o;
   logic [CKW-1:0] ckpt_o;
   logic           restore_v_i = 1'b0;
   logic [CKW-1:0] restore_ckpt_i = '0;
   logic           restore_call_i = 1'b0, restore_return_i = 1'b0;
   logic [VW-1:0]  restore_addr_i = '0;

   bp_fe_ras_stack #(.vaddr_width_p(VW), .ras_els_p(E)) dut (
      .clk_i(clk), .reset_i(reset_i), .call_i(call_i), .return_i(return_i),
      .addr_i(addr_i), .tgt_o(tgt_o), .v_o(v_o), .ckpt_o(ckpt_o),
      .restore_v_i(restore_v_i), .restore_ckpt_i(restore_ckpt_i),
      .restore_call_i(restore_call_i), .restore_return_i(restore_return_i),
      .restore_addr_i(restore_addr_i)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference: a ring of E slots with a top index and an occupancy count.
   int            m_ptr, m_cnt;
   logic [VW-1:0] m_mem [E];
   logic [CKW-1:0] hist [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [CKW-1:0] m_ckpt();
      return {PW'(m_ptr), CW'(m_cnt), m_mem[m_ptr]};
   endfunction

   function automatic void m_apply(input int bp, input int bc, input logic c, input logic r,
                                   input logic [VW-1:0] a);
      m_ptr = bp;
      m_cnt = bc;
      if (c && r) begin
         m_mem[bp] = a;
         m_cnt = (bc > 1) ? bc : 1;
      end else if (c) begin
         m_ptr = (bp + 1) % E;
         m_mem[m_ptr] = a;
         m_cnt = (bc + 1 > E) ? E : bc + 1;
      end else if (r && bc > 0) begin
         m_ptr = (bp + E - 1) % E;
         m_cnt = bc - 1;
      end
   endfunction

   function automatic void m_step();
      logic [PW-1:0] cp;
      logic [CW-1:0] cc;
      logic [VW-1:0] ct;
      if (reset_i) begin
         m_ptr = 0;
         m_cnt = 0;
         hist.delete();
      end else if (restore_v_i) begin
         {cp, cc, ct} = restore_ckpt_i;
         m_mem[int'(cp)] = ct;
         m_apply(int'(cp), int'(cc), restore_call_i, restore_return_i, restore_addr_i);
      end else begin
         m_apply(m_ptr, m_cnt, call_i, return_i, addr_i);
      end
   endfunction

   task automatic check_outputs();
      chk("v", 64'(v_o), 64'(m_cnt != 0));
      chk("ckpt_ptr", 64'(ckpt_o[CKW-1 -: PW]), 64'(m_ptr));
      chk("ckpt_cnt", 64'(ckpt_o[CKW-PW-1 -: CW]), 64'(m_cnt));
      if (m_cnt != 0) begin
         chk("tgt", 64'(tgt_o), 64'(m_mem[m_ptr]));
         chk("ckpt_top", 64'(ckpt_o[VW-1:0]), 64'(m_mem[m_ptr]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
      check_outputs();
      reset_i = 1'b0; call_i = 1'b0; return_i = 1'b0; restore_v_i = 1'b0;
      restore_call_i = 1'b0; restore_return_i = 1'b0;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      tick();
   endtask

   task automatic push(input logic [VW-1:0] a);
      call_i = 1'b1; addr_i = a;
      tick();
   endtask

   task automatic pop();
      return_i = 1'b1;
      tick();
   endtask

   task automatic restore(input logic [CKW-1:0] ck, input logic c, input logic r,
                          input logic [VW-1:0] a);
      restore_v_i = 1'b1; restore_ckpt_i = ck;
      restore_call_i = c; restore_return_i = r; restore_addr_i = a;
      tick();
   endtask

   logic [CKW-1:0] saved;

   initial begin
      for (int i = 0; i < E; i++) m_mem[i] = '0;
      #2;
      // Reset, then idle
      do_reset();
      tick();
      chk("reset_v", 64'(v_o), 64'd0);
      chk("reset_cnt", 64'(ckpt_o[CKW-PW-1 -: CW]), 64'd0);

      // LIFO order
      push('h100); push('h200); push('h300);
      chk("lifo_top", 64'(tgt_o), 64'h300);
      pop(); chk("lifo_pop1", 64'(tgt_o), 64'h200);
      pop(); chk("lifo_pop2", 64'(tgt_o), 64'h100);
      pop(); chk("lifo_empty", 64'(v_o), 64'd0);

      // Overflow: E+2 pushes keep only the newest E
      do_reset();
      for (int i = 1; i <= E + 2; i++) push(VW'(i * 'h10));
      chk("ovf_cnt", 64'(ckpt_o[CKW-PW-1 -: CW]), 64'(E));
      for (int i = E + 2; i >= 3; i--) begin
         chk("ovf_top", 64'(tgt_o), 64'(i * 'h10));
         pop();
      end
      chk("ovf_empty", 64'(v_o), 64'd0);
      saved = ckpt_o;
      pop();
      chk("underflow_ptr", 64'(ckpt_o[CKW-1 -: PW]), 64'(saved[CKW-1 -: PW]));
      chk("underflow_cnt", 64'(ckpt_o[CKW-PW-1 -: CW]), 64'd0);

      // Wrong-path repair
      do_reset();
      push('hA0); push('hB0);
      saved = m_ckpt();
      pop(); push('hEE);
      restore(saved, 1'b0, 1'b0, '0);
      chk("repair_tgt", 64'(tgt_o), 64'hB0);
      chk("repair_cnt", 64'(ckpt_o[CKW-PW-1 -: CW]), 64'd2);
      pop();
      chk("repair_pop", 64'(tgt_o), 64'hA0);

      // Restore with re-applied call
      do_reset();
      push('hA0); push('hB0);
      restore({PW'(1), CW'(2), VW'('hB0)}, 1'b1, 1'b0, 'hC0);
      chk("rcall_tgt", 64'(tgt_o), 64'hC0);
      chk("rcall_cnt", 64'(ckpt_o[CKW-PW-1 -: CW]), 64'd3);
      pop();
      chk("rcall_pop", 64'(tgt_o), 64'hB0);

      // Simultaneous call and return
      do_reset();
      push('h11); push('h22);
      call_i = 1'b1; return_i = 1'b1; addr_i = 'h77;
      tick();
      chk("swap_tgt", 64'(tgt_o), 64'h77);
      chk("swap_cnt", 64'(ckpt_o[CKW-PW-1 -: CW]), 64'd2);

      // Restore beats a concurrent call
      do_reset();
      push('h11);
      saved = m_ckpt();
      push('h22); push('h33);
      call_i = 1'b1; addr_i = 'h99;
      restore(saved, 1'b0, 1'b0, '0);
      chk("rst_pri_tgt", 64'(tgt_o), 64'h11);
      chk("rst_pri_cnt", 64'(ckpt_o[CKW-PW-1 -: CW]), 64'd1);

      // Reset beats restore
      push('h44);
      reset_i = 1'b1;
      restore(saved, 1'b1, 1'b0, 'h55);
      chk("reset_pri_v", 64'(v_o), 64'd0);

      // Randomized mix, restoring to checkpoints the model saw earlier
      for (int n = 0; n < 400; n++) begin
         int r;
         r = $urandom_range(0, 99);
         hist.push_back(m_ckpt());
         if (hist.size() > 16) void'(hist.pop_front());
         addr_i = VW'({$urandom, $urandom});
         call_i = 1'($urandom); return_i = 1'($urandom);
         if (r < 3) begin
            do_reset();
         end else if (r < 18 && hist.size() > 0) begin
            restore(hist[$urandom_range(0, hist.size() - 1)], 1'($urandom), 1'($urandom),
                    VW'({$urandom, $urandom}));
         end else begin
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
